lfsr_keystream_gen: RTL and testbench

- Parametrised keystream generator for the XOR cipher datapath.
- Steps a WIDTH-bit LFSR in Galois or Fibonacci mode, one bit per cycle, and packs STEP successive output bits into a word.
- Words are offered on a valid/ready interface with backpressure; the LFSR stalls when the consumer stalls.
- Adds registered taps/mode, lock-up detection and an accepted-word counter.

---
 rtl/lfsr_keystream_gen.sv | 172 +++++++++++++++++
 tb/tb_lfsr_keystream_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_keystream_gen.sv
// lfsr_keystream_gen
//   Keystream source for the XOR cipher datapath. A WIDTH-bit LFSR (Galois or
//   Fibonacci) is stepped one bit per cycle. STEP successive output bits are
//   packed into a word, with bit 0 holding the earliest bit. Words are offered
//   on a valid/ready interface, and the LFSR stalls while the consumer stalls.
//
//   Ports
//     clk, rst            clock (rising edge), async active-high reset
//     ld                  load strobe; samples cfg_seed / cfg_taps / cfg_mode
//     cfg_seed, cfg_taps  seed value and tap mask (WIDTH bits)
//     cfg_mode            0 = Galois, 1 = Fibonacci
//     out_data/out_valid  keystream word and its valid flag
//     out_ready           consumer accepts out_data
//     lockup              LFSR state is all-zero; generator halted
//     running             FSM is in RUN
//     state_o             current LFSR state
//     word_cnt            words accepted since the last ld (saturating)
//
//   state     | meaning
//   ----------+----------------------------------------
//   ST_IDLE   | unseeded since reset, no stepping
//   ST_RUN    | stepping and packing keystream words
//   ST_LOCKED | zero state reached; waits for a non-zero ld
module lfsr_keystream_gen #(
    parameter int WIDTH = 64,
    parameter int STEP  = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] cfg_seed,
    input  logic [WIDTH-1:0] cfg_taps,
    input  logic             cfg_mode,
    output logic [STEP-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lockup,
    output logic             running,
    output logic [WIDTH-1:0] state_o,
    output logic [CNT_W-1:0] word_cnt
);
    localparam int ACW = $clog2(STEP + 1);
    localparam logic [ACW-1:0] ACC_FULL = ACW'(STEP);
    localparam logic [ACW-1:0] ACC_LAST = ACW'(STEP - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_LOCKED} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] taps_q, taps_d;
    logic             mode_q, mode_d;
    logic [STEP-1:0]  acc_q, acc_d;
    logic [ACW-1:0]   acc_cnt_q, acc_cnt_d;
    logic [STEP-1:0]  out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             lockup_q, lockup_d;
    logic             running_q, running_d;

    logic             collect;
    logic             out_free;
    logic             bit_k;
    logic [WIDTH-1:0] step_next;
    logic [STEP-1:0]  acc_fill;

    always_comb begin
        bit_k    = state_q[0];
        collect  = (fsm_q == ST_RUN) && (acc_cnt_q < ACC_FULL);
        out_free = !out_valid_q || out_ready;

        if (mode_q)
            step_next = {^(state_q & taps_q), state_q[WIDTH-1:1]};
        else if (bit_k)
            step_next = (state_q >> 1) ^ taps_q;
        else
            step_next = state_q >> 1;

        // acc with the new bit written into slot acc_cnt
        acc_fill = (acc_q & ~(STEP'(1) << acc_cnt_q)) | (STEP'(bit_k) << acc_cnt_q);

        fsm_d       = fsm_q;
        state_d     = state_q;
        taps_d      = taps_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        word_cnt_d  = word_cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            if (word_cnt_q != {CNT_W{1'b1}})
                word_cnt_d = word_cnt_q + CNT_W'(1);
        end

        if (collect) begin
            state_d = step_next;
            acc_d   = acc_fill;
            if (step_next == '0) begin
                // Zero state: the partial word is dropped, a pending word survives.
                fsm_d     = ST_LOCKED;
                acc_cnt_d = '0;
            end else if (acc_cnt_q == ACC_LAST) begin
                if (out_free) begin
                    out_data_d  = acc_fill;
                    out_valid_d = 1'b1;
                    acc_cnt_d   = '0;
                end else begin
                    acc_cnt_d = ACC_FULL;
                end
            end else begin
                acc_cnt_d = acc_cnt_q + ACW'(1);
            end
        end else if ((acc_cnt_q == ACC_FULL) && out_free) begin
            out_data_d  = acc_q;
            out_valid_d = 1'b1;
            acc_cnt_d   = '0;
        end

        // Load overrides everything else in the same cycle.
        if (ld) begin
            state_d     = cfg_seed;
            taps_d      = cfg_taps;
            mode_d      = cfg_mode;
            acc_cnt_d   = '0;
            out_valid_d = 1'b0;
            word_cnt_d  = '0;
            fsm_d       = (cfg_seed != '0) ? ST_RUN : ST_LOCKED;
        end

        lockup_d  = (fsm_d == ST_LOCKED);
        running_d = (fsm_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            taps_q      <= '0;
            mode_q      <= 1'b0;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
            lockup_q    <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            taps_q      <= taps_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            word_cnt_q  <= word_cnt_d;
            lockup_q    <= lockup_d;
            running_q   <= running_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign lockup    = lockup_q;
    assign running   = running_q;
    assign state_o   = state_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_lfsr_keystream_gen.sv
// Bench for lfsr_keystream_gen (WIDTH=8, STEP=4, CNT_W=8).
// The reference model expands each seed into its expected word stream and
// queues it at load time. The monitor pops one word on every accepted handshake.
module tb_lfsr_keystream_gen;
    localparam int W = 8;
    localparam int S = 4;
    localparam int C = 8;

    logic         clk;
    logic         rst;
    logic         ld;
    logic [W-1:0] cfg_seed;
    logic [W-1:0] cfg_taps;
    logic         cfg_mode;
    logic [S-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         lockup;
    logic         running;
    logic [W-1:0] state_o;
    logic [C-1:0] word_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;
    logic [S-1:0] exp_q[$];

    lfsr_keystream_gen #(.WIDTH(W), .STEP(S), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .ld(ld),
        .cfg_seed(cfg_seed), .cfg_taps(cfg_taps), .cfg_mode(cfg_mode),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .lockup(lockup), .running(running), .state_o(state_o), .word_cnt(word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One LFSR step from the arithmetic definition of each mode.
    function automatic logic [W-1:0] model_next(input logic [W-1:0] s, input logic [W-1:0] t,
                                                input logic m);
        int unsigned par;
        if (m) begin
            par = $countones(s & t) % 2;
            return (s >> 1) | (W'(par) << (W - 1));
        end
        if (s % 2 == 1) return (s >> 1) ^ t;
        return s >> 1;
    endfunction

    // Expand a seed into its word stream; stops at the zero state, dropping the partial word.
    task automatic load_model(input logic [W-1:0] seed, input logic [W-1:0] taps, input logic mode);
        logic [W-1:0] s;
        logic [S-1:0] w;
        int nb;
        exp_q.delete();
        s  = seed;
        w  = '0;
        nb = 0;
        if (s == '0) return;
        while (exp_q.size() < 300) begin
            w[nb] = s[0];
            s = model_next(s, taps, mode);
            if (s == '0) break;
            nb++;
            if (nb == S) begin
                exp_q.push_back(w);
                nb = 0;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_ld(input logic [W-1:0] seed, input logic [W-1:0] taps, input logic mode);
        ld       = 1'b1;
        cfg_seed = seed;
        cfg_taps = taps;
        cfg_mode = mode;
        load_model(seed, taps, mode);
        hs_cnt = 0;
        tick(1);
        ld       = 1'b0;
        cfg_seed = W'($urandom);
        cfg_taps = W'($urandom);
        cfg_mode = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [63:0] sat_cnt(input int n);
        return (n > 255) ? 64'd255 : 64'(n);
    endfunction

    // Monitor: a handshake seen at the negedge completes at the next posedge.
    initial begin
        logic [S-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && !ld && out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(out_data), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", 64'(out_data), 64'(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncyc;
        logic [W-1:0] seed, taps;
        logic mode;

        rst = 1'b1; ld = 1'b0; cfg_seed = '0; cfg_taps = '0; cfg_mode = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_state", 64'(state_o), 0);
        check("rst_running", 64'(running), 0);
        check("rst_lockup", 64'(lockup), 0);
        check("rst_word_cnt", 64'(word_cnt), 0);
        check("rst_out_data", 64'(out_data), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        tick(5);
        check("idle_no_step", 64'(state_o), 0);
        check("idle_no_valid", 64'(out_valid), 0);

        // Galois basic stream
        out_ready = 1'b1;
        do_ld(8'h01, 8'hB8, 1'b0);
        check("t1_running", 64'(running), 1);
        tick(3);
        check("t1_valid_early", 64'(out_valid), 0);
        tick(1);
        check("t1_valid_at_step", 64'(out_valid), 1);
        check("t1_word0", 64'(out_data), 64'h1);
        check("t1_state0", 64'(state_o), 64'h17);
        tick(4);
        check("t1_word1", 64'(out_data), 64'h7);
        check("t1_state1", 64'(state_o), 64'h64);
        tick(1);
        check("t1_word_cnt", 64'(word_cnt), 2);

        // Fibonacci basic stream
        do_ld(8'h81, 8'hB8, 1'b1);
        tick(4);
        check("t2_word0", 64'(out_data), 64'h1);
        check("t2_state0", 64'(state_o), 64'h38);

        // Backpressure
        out_ready = 1'b0;
        do_ld(8'h01, 8'hB8, 1'b0);
        tick(4);
        check("t3_word0", 64'(out_data), 64'h1);
        tick(4);
        check("t3_state_full", 64'(state_o), 64'h64);
        tick(2);
        check("t3_state_frozen", 64'(state_o), 64'h64);
        check("t3_data_held", 64'(out_data), 64'h1);
        check("t3_valid_held", 64'(out_valid), 1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("t3_word1", 64'(out_data), 64'h7);
        check("t3_valid1", 64'(out_valid), 1);
        check("t3_word_cnt", 64'(word_cnt), 1);
        tick(1);
        check("t3_resume", 64'(state_o), 64'h32);

        // Lock-up
        out_ready = 1'b1;
        do_ld(8'h01, 8'hB8, 1'b1);
        tick(1);
        check("t4_lockup", 64'(lockup), 1);
        check("t4_not_running", 64'(running), 0);
        check("t4_state_zero", 64'(state_o), 0);
        tick(8);
        check("t4_no_words", 64'(out_valid), 0);
        do_ld(8'h81, 8'hB8, 1'b1);
        check("t4_relock_clear", 64'(lockup), 0);
        check("t4_rerun", 64'(running), 1);
        do_ld(8'h00, 8'hB8, 1'b0);
        check("t4_zero_seed_lock", 64'(lockup), 1);
        check("t4_zero_seed_run", 64'(running), 0);

        // ld wins over a same-cycle handshake
        do_ld(8'h01, 8'hB8, 1'b0);
        tick(4);
        check("t5_valid_before", 64'(out_valid), 1);
        do_ld(8'h81, 8'hB8, 1'b1);
        check("t5_valid_flushed", 64'(out_valid), 0);
        check("t5_word_cnt", 64'(word_cnt), 0);
        check("t5_state_seed", 64'(state_o), 64'h81);
        tick(4);
        check("t5_word0", 64'(out_data), 64'h1);
        check("t5_state0", 64'(state_o), 64'h38);

        // Randomized configs and backpressure
        for (int r = 0; r < 12; r++) begin
            seed = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
            taps = W'($urandom);
            mode = 1'($urandom_range(0, 1));
            do_ld(seed, taps, mode);
            ncyc = $urandom_range(20, 150);
            for (int c = 0; c < ncyc; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick(1);
            end
            out_ready = 1'b0;
            tick(1);
            check("rand_word_cnt", 64'(word_cnt), sat_cnt(hs_cnt));
        end

        // word_cnt saturation
        out_ready = 1'b1;
        do_ld(8'h01, 8'hB8, 1'b0);
        tick(4 * 260);
        out_ready = 1'b0;
        tick(1);
        check("sat_word_cnt", 64'(word_cnt), 64'd255);
        check("sat_enough_words", 64'(hs_cnt >= 255), 1);

        // Async reset mid-run
        out_ready = 1'b1;
        do_ld(8'h81, 8'hB8, 1'b1);
        tick(6);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("arst_valid", 64'(out_valid), 0);
        check("arst_data", 64'(out_data), 0);
        check("arst_state", 64'(state_o), 0);
        check("arst_running", 64'(running), 0);
        check("arst_lockup", 64'(lockup), 0);
        check("arst_word_cnt", 64'(word_cnt), 0);
        #4;
        rst = 1'b0;
        tick(10);
        check("arst_no_step", 64'(state_o), 0);
        check("arst_no_valid", 64'(out_valid), 0);
        do_ld(8'h81, 8'hB8, 1'b1);
        tick(4);
        check("arst_reload_word", 64'(out_data), 64'h1);

        out_ready = 1'b0;
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
